// File: rtl/ones_pattern_gen.sv
// Purpose: streams every WIDTH-bit word with exactly k ones, in ascending order.
// Latency: start to first valid is 1 cycle; each accepted word is replaced on the same edge.
// Backpressure: valid/ready; dat_out, last and n_sent hold while valid & !ready.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin an enumeration (sampled only when idle)
//   count_in       target population count k, latched when start is accepted
//   ready          consumer accepts dat_out this cycle
//   dat_out        current word (exactly k bits set), qualified by valid
//   valid, last    word valid / final word of the sequence
//   busy           enumeration in progress
//   err            one-cycle pulse when a start with k > WIDTH is rejected
//   n_sent         words accepted in the current or most recent sequence
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  input  logic             ready,
  output logic [WIDTH-1:0] dat_out,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] n_sent
);

  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;
  localparam logic [CW-1:0] K_MAX   = CW'(WIDTH);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_dat;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_err;
  logic [WIDTH-1:0] r_n_sent;

  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_r;
  logic [CW-1:0]    w_tz;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_last_word;
  logic [WIDTH-1:0] w_first_new;
  logic [WIDTH-1:0] w_last_new;

  // k ones packed at the bottom: the smallest word of weight k.
  function automatic logic [WIDTH-1:0] f_lo_mask(input logic [CW-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < int'(k));
    end
    return m;
  endfunction

  // k ones packed at the top: the largest word of weight k.
  function automatic logic [WIDTH-1:0] f_hi_mask(input logic [CW-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= WIDTH - int'(k));
    end
    return m;
  endfunction

  // Gosper's next-combination step. The shift by tz(c) replaces the usual
  // division by c, since c is a single set bit.
  assign w_c = r_dat & (-r_dat);
  assign w_r = r_dat + w_c;

  always_comb begin
    w_tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_c[i]) begin
        w_tz = CW'(i);
      end
    end
  end

  assign w_next      = (((w_r ^ r_dat) >> 2) >> w_tz) | w_r;
  assign w_last_word = f_hi_mask(r_k);
  assign w_first_new = f_lo_mask(count_in);
  assign w_last_new  = f_hi_mask(count_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_dat    <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_n_sent <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          if (count_in > K_MAX) begin
            r_err <= 1'b1;
          end else begin
            r_k      <= count_in;
            r_state  <= ST_RUN;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_n_sent <= '0;
            r_dat    <= w_first_new;
            // k=0 and k=WIDTH have a single word, which is first and last.
            r_last   <= (w_first_new == w_last_new);
          end
        end
      end else begin
        if (r_valid && ready) begin
          r_n_sent <= r_n_sent + WIDTH'(1);
          if (r_last) begin
            // Final word stays on dat_out for inspection after the run.
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_dat  <= w_next;
            r_last <= (w_next == w_last_word);
          end
        end
      end
    end
  end

  assign dat_out = r_dat;
  assign valid   = r_valid;
  assign last    = r_last;
  assign busy    = r_busy;
  assign err     = r_err;
  assign n_sent  = r_n_sent;

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] count_in;
  logic       ready;
  logic [7:0] dat_out;
  logic       valid;
  logic       last;
  logic       busy;
  logic       err;
  logic [7:0] n_sent;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_w[$];
  logic [7:0] got_w[$];
  logic       got_l[$];
  int         stab_viol;
  bit         err_seen;

  ones_pattern_gen #(.WIDTH(8), .CW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count_in (count_in),
    .ready    (ready),
    .dat_out  (dat_out),
    .valid    (valid),
    .last     (last),
    .busy     (busy),
    .err      (err),
    .n_sent   (n_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference list: brute-force scan of all 8-bit words by population count.
  task automatic build_exp(input int k);
    logic [7:0] v;
    exp_w.delete();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      if ($countones(v) == k) exp_w.push_back(v);
    end
  endtask

  // Present start for one edge; returns at posedge+1.
  task automatic do_start(input int k);
    start    = 1'b1;
    count_in = 4'(k);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Consume words until the last one transfers. poke>=0 raises start (k=2)
  // on that cycle; poke==-1 raises it on the cycle the last word transfers.
  task automatic drain(input bit rnd, input int poke, output bit timed_out);
    bit         hold;
    bit         fin;
    logic [7:0] h_dat;
    logic [7:0] h_n;
    logic       h_last;
    got_w.delete();
    got_l.delete();
    stab_viol = 0;
    err_seen  = 1'b0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 1000 && timed_out; cyc++) begin
      ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fin      = valid && ready && last;
      start    = (poke == cyc) || (poke == -1 && fin);
      count_in = 4'd2;
      if (valid && ready) begin
        got_w.push_back(dat_out);
        got_l.push_back(last);
      end
      hold   = valid && !ready;
      h_dat  = dat_out;
      h_last = last;
      h_n    = n_sent;
      @(posedge clk); #1;
      if (err) err_seen = 1'b1;
      if (hold && (valid !== 1'b1 || dat_out !== h_dat || last !== h_last || n_sent !== h_n))
        stab_viol++;
      if (fin) timed_out = 1'b0;
    end
    ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; ready = 1'b0; count_in = '0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (dat_out !== 8'h0) begin bad++; $display("FAIL reset_dat got=%h want=00", dat_out); end
    total++; if (n_sent !== 8'h0)  begin bad++; $display("FAIL reset_nsent got=%0d want=0", n_sent); end
    total++; if ({last, err} !== 2'b00) begin bad++; $display("FAIL reset_last_err got=%b want=00", {last, err}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_k4;
    bit to;
    build_exp(4);
    do_start(4);
    total++; if ({valid, busy, last} !== 3'b110) begin bad++; $display("FAIL k4_first_flags got=%b want=110", {valid, busy, last}); end
    total++; if (dat_out !== 8'h0F) begin bad++; $display("FAIL k4_first_word got=%h want=0f", dat_out); end
    total++; if (n_sent !== 8'd0)   begin bad++; $display("FAIL k4_first_nsent got=%0d want=0", n_sent); end
    drain(1'b0, -2, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL k4_timeout got=%b want=0", to); end
    total++; if (got_w.size() != 70) begin bad++; $display("FAIL k4_count got=%0d want=70", got_w.size()); end
    total++; if (got_w.size() >= 3 && {got_w[1], got_w[2]} !== 16'h171B)
      begin bad++; $display("FAIL k4_second_third got=%h %h want=17 1b", got_w[1], got_w[2]); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
        begin bad++; $display("FAIL k4_word[%0d] got=%h/%b want=%h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1); end
    end
    total++; if (n_sent !== 8'd70) begin bad++; $display("FAIL k4_nsent got=%0d want=70", n_sent); end
    total++; if ({valid, busy, last} !== 3'b000) begin bad++; $display("FAIL k4_end_flags got=%b want=000", {valid, busy, last}); end
    total++; if (dat_out !== 8'hF0) begin bad++; $display("FAIL k4_hold_final got=%h want=f0", dat_out); end
  endtask

  // k=1 also asserts start on the final transfer, which must be ignored.
  task automatic test_small_k;
    int ks[3];
    int ns[3];
    bit to;
    ks = '{1, 8, 0};
    ns = '{8, 1, 1};
    for (int j = 0; j < 3; j++) begin
      build_exp(ks[j]);
      do_start(ks[j]);
      total++; if (dat_out !== exp_w[0] || last !== (ns[j] == 1))
        begin bad++; $display("FAIL k%0d_first got=%h/%b want=%h/%b", ks[j], dat_out, last, exp_w[0], ns[j] == 1); end
      drain(1'b0, (ks[j] == 1) ? -1 : -2, to);
      total++; if (to !== 1'b0 || got_w.size() != ns[j])
        begin bad++; $display("FAIL k%0d_count got=%0d to=%b want=%0d", ks[j], got_w.size(), to, ns[j]); end
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
        total++;
        if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1))
          begin bad++; $display("FAIL k%0d_word[%0d] got=%h/%b want=%h", ks[j], i, got_w[i], got_l[i], exp_w[i]); end
      end
      total++; if (n_sent !== 8'(ns[j])) begin bad++; $display("FAIL k%0d_nsent got=%0d want=%0d", ks[j], n_sent, ns[j]); end
      @(posedge clk); #1;
      total++; if ({valid, busy} !== 2'b00) begin bad++; $display("FAIL k%0d_idle_after got=%b want=00", ks[j], {valid, busy}); end
    end
  endtask

  task automatic test_err;
    bit to;
    do_start(9);
    total++; if ({err, valid, busy} !== 3'b100) begin bad++; $display("FAIL err_pulse got=%b want=100", {err, valid, busy}); end
    @(posedge clk); #1;
    total++; if ({err, valid, busy} !== 3'b000) begin bad++; $display("FAIL err_one_cycle got=%b want=000", {err, valid, busy}); end
    build_exp(2);
    do_start(2);
    total++; if (dat_out !== 8'h03 || valid !== 1'b1) begin bad++; $display("FAIL k2_first got=%h v=%b want=03 v=1", dat_out, valid); end
    drain(1'b0, -2, to);
    total++; if (to !== 1'b0 || got_w.size() != 28) begin bad++; $display("FAIL k2_count got=%0d want=28", got_w.size()); end
    total++; if (got_w.size() > 0 && got_w[got_w.size()-1] !== 8'hC0) begin bad++; $display("FAIL k2_last got=%h want=c0", got_w[got_w.size()-1]); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL k2_word[%0d] got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_backpressure;
    bit to;
    build_exp(3);
    do_start(3);
    drain(1'b1, -2, to);
    total++; if (to !== 1'b0 || got_w.size() != 56) begin bad++; $display("FAIL bp_count got=%0d to=%b want=56", got_w.size(), to); end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d violations want=0", stab_viol); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
    total++; if (n_sent !== 8'd56) begin bad++; $display("FAIL bp_nsent got=%0d want=56", n_sent); end
  endtask

  task automatic test_start_ignored;
    bit to;
    build_exp(5);
    do_start(5);
    drain(1'b0, 7, to);
    total++; if (to !== 1'b0 || got_w.size() != 56) begin bad++; $display("FAIL restart_count got=%0d want=56", got_w.size()); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL restart_err got=%b want=0", err_seen); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL restart_word[%0d] got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_async_reset;
    bit to;
    build_exp(4);
    do_start(4);
    ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    ready = 1'b0;
    total++; if (n_sent !== 8'd10 || dat_out !== exp_w[10])
      begin bad++; $display("FAIL ar_progress got=%0d/%h want=10/%h", n_sent, dat_out, exp_w[10]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({valid, busy, last} !== 3'b000) begin bad++; $display("FAIL ar_flags got=%b want=000", {valid, busy, last}); end
    total++; if (dat_out !== 8'h00 || n_sent !== 8'h00) begin bad++; $display("FAIL ar_clear got=%h/%0d want=00/0", dat_out, n_sent); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(4);
    total++; if (dat_out !== 8'h0F || n_sent !== 8'd0) begin bad++; $display("FAIL ar_restart got=%h/%0d want=0f/0", dat_out, n_sent); end
    drain(1'b0, -2, to);
    total++; if (to !== 1'b0 || got_w.size() != 70 || n_sent !== 8'd70)
      begin bad++; $display("FAIL ar_full_run got=%0d/%0d want=70/70", got_w.size(), n_sent); end
  endtask

  initial begin
    test_reset();
    test_k4();
    test_small_k();
    test_err();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
